fetch_unit: RTL and testbench

Instruction fetch stage that produces the instruction stream consumed by the control unit and datapath decode logic, and acts on that decoder's PCSrc branch/jump decision. Maintains the fetch PC and issues word reads to a synchronous instruction memory with one-cycle read latency. Presents each fetched instruction with its PC to decode over a valid/ready handshake. Absorbs decode backpressure with a one-entry skid buffer, and flushes on redirect.

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Keeps the fetch PC, issues word reads to a one-cycle-latency instruction
// memory, and hands fetched instructions to decode over valid/ready. A
// one-entry skid buffer absorbs decode backpressure; redirect flushes all
// fetched-but-unconsumed state and restarts at the target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    // One fetched instruction together with its address.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // Architectural state
    logic [31:0] fetch_pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic        out_v;
    entry_t      out_q;
    logic        skid_v;
    entry_t      skid_q;

    // Next-state values
    logic [31:0] fetch_pc_n;
    logic        inflight_n;
    logic [31:0] inflight_pc_n;
    logic        out_v_n;
    entry_t      out_n;
    logic        skid_v_n;
    entry_t      skid_n;

    // Derived control
    logic [1:0]  occ;
    logic [1:0]  occ_after;
    logic        xfer;
    logic        out_free;
    entry_t      rsp;
    logic        skid_overflow;
    logic        unused_redirect_lsbs;

    // Byte offset of the redirect target is dropped: fetch is word-aligned.
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Occupancy counts every instruction already owned by this stage,
    // including the one whose read data arrives this cycle.
    assign occ       = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, inflight};
    assign xfer      = out_v & ready_i;
    assign occ_after = occ - {1'b0, xfer};

    // Only request when the returning word is guaranteed a slot next cycle.
    assign imem_req_o  = rst_n_i & ~redirect_i & (occ_after < 2'd2);
    assign imem_addr_o = fetch_pc;

    // The output slot can take a new entry if it is empty or being consumed.
    assign out_free = ~out_v | xfer;
    assign rsp      = '{instr: imem_rdata_i, pc: inflight_pc};

    // A response with nowhere to go: skid full and output slot stalled.
    assign skid_overflow = rst_n_i & ~redirect_i & inflight & skid_v & ~out_free;

    // Decode-facing outputs come straight from the output entry registers.
    assign valid_o    = out_v;
    assign instr_o    = out_q.instr;
    assign pc_o       = out_q.pc;
    assign pc_plus4_o = out_q.pc + 32'd4;

    // Next-state: redirect flush first, otherwise request issue, skid drain
    // and response placement (skid always drains ahead of newer data).
    always_comb begin
        fetch_pc_n    = fetch_pc;
        inflight_n    = 1'b0;
        inflight_pc_n = inflight_pc;
        out_v_n       = out_v;
        out_n         = out_q;
        skid_v_n      = skid_v;
        skid_n        = skid_q;

        if (redirect_i) begin
            // Flush everything; a response arriving now belongs to the old
            // path and is simply not captured.
            fetch_pc_n = {redirect_pc_i[31:2], 2'b00};
            out_v_n    = 1'b0;
            skid_v_n   = 1'b0;
            inflight_n = 1'b0;
        end else begin
            inflight_n = imem_req_o;
            if (imem_req_o) begin
                inflight_pc_n = fetch_pc;
                fetch_pc_n    = fetch_pc + 32'd4;
            end

            if (out_free) begin
                if (skid_v) begin
                    // Older skid entry moves up; a response refills skid.
                    out_n    = skid_q;
                    out_v_n  = 1'b1;
                    skid_v_n = 1'b0;
                    if (inflight) begin
                        skid_n   = rsp;
                        skid_v_n = 1'b1;
                    end
                end else if (inflight) begin
                    out_n   = rsp;
                    out_v_n = 1'b1;
                end else begin
                    out_v_n = 1'b0;
                end
            end else if (inflight) begin
                // Output stalled: park the response in skid.
                skid_n   = rsp;
                skid_v_n = 1'b1;
            end
        end
    end

    // State register; asynchronous reset returns to the first fetch address
    // and drops any response still due from before reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            out_v       <= 1'b0;
            out_q       <= '0;
            skid_v      <= 1'b0;
            skid_q      <= '0;
        end else begin
            fetch_pc    <= fetch_pc_n;
            inflight    <= inflight_n;
            inflight_pc <= inflight_pc_n;
            out_v       <= out_v_n;
            out_q       <= out_n;
            skid_v      <= skid_v_n;
            skid_q      <= skid_n;
        end
    end

    // The request gating must make skid overflow unreachable.
    a_no_skid_overflow : assert property (
        @(posedge clk_i) disable iff (!rst_n_i) !skid_overflow
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: main instance (RESET_PC=0) checked by a PC
// scoreboard plus per-scenario tasks; a second instance covers PC wrap.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;

    logic        w_rst_n = 1'b1;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata = 32'h0;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;

    int checks = 0;
    int failures = 0;

    // Scoreboard: PCs of requested instructions in issue order.
    logic [31:0] sb_q[$];
    logic [31:0] exp_fetch = 32'h0;
    logic        prev_hold = 1'b0;
    logic [31:0] hold_pc = 32'h0;
    logic [31:0] hold_instr = 32'h0;
    logic [31:0] exp_pc;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk_i(clk_i), .rst_n_i(w_rst_n),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_rdata_i(w_rdata),
        .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc),
        .valid_o(w_valid), .ready_i(w_ready),
        .instr_o(w_instr), .pc_o(w_pc), .pc_plus4_o(w_pc4)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory: word at byte address A holds A/4, one-cycle latency.
    always @(posedge clk_i) begin
        imem_rdata_i <= imem_req_o ? (imem_addr_o >> 2) : 32'hDEAD_BEEF;
        w_rdata      <= w_req ? (w_addr >> 2) : 32'hDEAD_BEEF;
    end

    // Scoreboard monitor on the falling edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                sb_q.delete();
                exp_fetch = 32'h0;
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    checks++;
                    if (valid_o !== 1'b1 || pc_o !== hold_pc || instr_o !== hold_instr) begin
                        failures++;
                        $display("FAIL stall_hold: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                                 valid_o, pc_o, instr_o, hold_pc, hold_instr);
                    end
                end
                if (redirect_i) begin
                    checks++;
                    if (imem_req_o !== 1'b0) begin
                        failures++;
                        $display("FAIL redirect_no_req: got req=%b, want 0", imem_req_o);
                    end
                    sb_q.delete();
                    exp_fetch = {redirect_pc_i[31:2], 2'b00};
                end else begin
                    if (valid_o && ready_i) begin
                        checks++;
                        if (sb_q.size() == 0) begin
                            failures++;
                            $display("FAIL sb_empty: got transfer pc=%h, want none", pc_o);
                        end else begin
                            exp_pc = sb_q.pop_front();
                            if (pc_o !== exp_pc || instr_o !== (exp_pc >> 2) || pc_plus4_o !== exp_pc + 32'd4) begin
                                failures++;
                                $display("FAIL sb_data: got pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h",
                                         pc_o, instr_o, pc_plus4_o, exp_pc, exp_pc >> 2, exp_pc + 32'd4);
                            end
                        end
                    end
                    if (imem_req_o) begin
                        checks++;
                        if (imem_addr_o !== exp_fetch) begin
                            failures++;
                            $display("FAIL req_addr: got %h, want %h", imem_addr_o, exp_fetch);
                        end
                        sb_q.push_back(exp_fetch);
                        exp_fetch = exp_fetch + 32'd4;
                    end
                    checks++;
                    if (sb_q.size() > 2) begin
                        failures++;
                        $display("FAIL occupancy: got %0d, want <=2", sb_q.size());
                    end
                end
                prev_hold  = valid_o & ~ready_i & ~redirect_i;
                hold_pc    = pc_o;
                hold_instr = instr_o;
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #2;
        rst_n_i = 1'b0;
        w_rst_n = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0500;
        cyc();
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b, want 0", valid_o); end
        checks++; if (instr_o !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h, want 0", instr_o); end
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h, want 0", pc_o); end
        checks++; if (pc_plus4_o !== 32'h4) begin failures++; $display("FAIL rst_pc4: got %h, want 4", pc_plus4_o); end
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req: got %b, want 0", imem_req_o); end
        checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h, want 0", imem_addr_o); end
        cyc();
        redirect_i = 1'b0;
        rst_n_i = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] e;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            e = 32'(4 * i);
            checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== e) begin
                failures++; $display("FAIL stream_req: got req=%b addr=%h, want req=1 addr=%h", imem_req_o, imem_addr_o, e);
            end
            checks++; if (valid_o !== (i >= 2)) begin
                failures++; $display("FAIL stream_valid: cycle %0d got %b, want %b", i, valid_o, (i >= 2));
            end
            if (i >= 2) begin
                e = 32'(4 * (i - 2));
                checks++; if (pc_o !== e || instr_o !== (e >> 2)) begin
                    failures++; $display("FAIL stream_pc: got pc=%h instr=%h, want pc=%h instr=%h", pc_o, instr_o, e, e >> 2);
                end
            end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_pc, held_instr, e;
        held_pc = 32'h0;
        held_instr = 32'h0;
        ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (k == 0) begin held_pc = pc_o; held_instr = instr_o; end
            checks++; if (valid_o !== 1'b1 || pc_o !== held_pc || instr_o !== held_instr) begin
                failures++; $display("FAIL bp_hold: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                                     valid_o, pc_o, instr_o, held_pc, held_instr);
            end
            if (k >= 1) begin
                checks++; if (imem_req_o !== 1'b0) begin
                    failures++; $display("FAIL bp_req_stop: stall %0d got req=%b, want 0", k, imem_req_o);
                end
            end
            cyc();
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (imem_req_o !== 1'b1) begin
            failures++; $display("FAIL bp_resume: got req=%b, want 1", imem_req_o);
        end
        for (int j = 0; j < 8; j++) begin
            if (j > 0) @(negedge clk_i);
            e = held_pc + 32'(4 * j);
            checks++; if (valid_o !== 1'b1 || pc_o !== e) begin
                failures++; $display("FAIL bp_contig: got v=%b pc=%h, want v=1 pc=%h", valid_o, pc_o, e);
            end
            cyc();
        end
    endtask

    task automatic test_redirect_inflight();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        @(negedge clk_i);
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rdi_req_t: got %b, want 0", imem_req_o); end
        cyc();
        redirect_i = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rdi_valid_t1: got %b, want 0", valid_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            failures++; $display("FAIL rdi_target_req: got req=%b addr=%h, want req=1 addr=00000100", imem_req_o, imem_addr_o);
        end
        cyc();
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rdi_valid_t2: got %b, want 0", valid_o); end
        cyc();
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== 32'h40) begin
            failures++; $display("FAIL rdi_target: got v=%b pc=%h instr=%h, want v=1 pc=00000100 instr=00000040", valid_o, pc_o, instr_o);
        end
        cyc();
    endtask

    task automatic test_redirect_full();
        ready_i = 1'b0;
        cyc();
        cyc();
        ready_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b1 || imem_req_o !== 1'b0) begin
            failures++; $display("FAIL rdf_t: got v=%b req=%b, want v=1 req=0", valid_o, imem_req_o);
        end
        cyc();
        redirect_i = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            failures++; $display("FAIL rdf_t1: got v=%b req=%b addr=%h, want v=0 req=1 addr=00000200", valid_o, imem_req_o, imem_addr_o);
        end
        cyc();
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rdf_t2: got v=%b, want 0", valid_o); end
        cyc();
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h200 || instr_o !== 32'h80) begin
            failures++; $display("FAIL rdf_target: got v=%b pc=%h instr=%h, want v=1 pc=00000200 instr=00000080", valid_o, pc_o, instr_o);
        end
        cyc();
    endtask

    task automatic test_random();
        int xfers;
        xfers = 0;
        for (int n = 0; n < 300; n++) begin
            ready_i = ($urandom_range(0, 3) != 0);
            redirect_i = ($urandom_range(0, 15) == 0);
            redirect_pc_i = $urandom & 32'h0000_3FFF;
            @(negedge clk_i);
            if (valid_o && ready_i && !redirect_i) xfers++;
            cyc();
        end
        redirect_i = 1'b0;
        ready_i = 1'b1;
        for (int n = 0; n < 4; n++) cyc();
        checks++; if (xfers < 50) begin
            failures++; $display("FAIL rand_progress: got %0d transfers, want >=50", xfers);
        end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0;
        cyc();
        cyc();
        #1;
        rst_n_i = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0 || pc_plus4_o !== 32'h4) begin
            failures++; $display("FAIL midrst_out: got v=%b instr=%h pc=%h pc4=%h, want v=0 instr=0 pc=0 pc4=4",
                                 valid_o, instr_o, pc_o, pc_plus4_o);
        end
        checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL midrst_req: got req=%b addr=%h, want req=0 addr=0", imem_req_o, imem_addr_o);
        end
        cyc();
        cyc();
        ready_i = 1'b1;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL midrst_c0: got v=%b req=%b addr=%h, want v=0 req=1 addr=0", valid_o, imem_req_o, imem_addr_o);
        end
        cyc();
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0 || imem_addr_o !== 32'h4) begin
            failures++; $display("FAIL midrst_c1: got v=%b addr=%h, want v=0 addr=4", valid_o, imem_addr_o);
        end
        cyc();
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'h0) begin
            failures++; $display("FAIL midrst_first: got v=%b pc=%h instr=%h, want v=1 pc=0 instr=0", valid_o, pc_o, instr_o);
        end
        cyc();
    endtask

    task automatic test_wrap();
        logic [31:0] e_addr[5];
        logic [31:0] e_pc[5];
        e_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
        e_pc   = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        w_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks++; if (w_req !== 1'b1 || w_addr !== e_addr[i]) begin
                failures++; $display("FAIL wrap_req: cycle %0d got req=%b addr=%h, want req=1 addr=%h", i, w_req, w_addr, e_addr[i]);
            end
            checks++; if (w_valid !== (i >= 2)) begin
                failures++; $display("FAIL wrap_valid: cycle %0d got %b, want %b", i, w_valid, (i >= 2));
            end
            if (i >= 2) begin
                checks++; if (w_pc !== e_pc[i] || w_instr !== (e_pc[i] >> 2) || w_pc4 !== e_pc[i] + 32'd4) begin
                    failures++; $display("FAIL wrap_pc: got pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h",
                                         w_pc, w_instr, w_pc4, e_pc[i], e_pc[i] >> 2, e_pc[i] + 32'd4);
                end
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_full();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
